// File: rtl/id_decode_pipe_pkg.sv
// MIPS32 decode types shared by the ID stage: instruction classes, opcodes,
// the decoded record and the combinational field-splitting function.
package mips_pkg;

   typedef enum logic [1:0] {
      IT_R = 2'd0,
      IT_I = 2'd1,
      IT_J = 2'd2
   } itype_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LB    = 6'h20;
   localparam logic [5:0] OP_LH    = 6'h21;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_LBU   = 6'h24;
   localparam logic [5:0] OP_LHU   = 6'h25;
   localparam logic [5:0] OP_SB    = 6'h28;
   localparam logic [5:0] OP_SH    = 6'h29;
   localparam logic [5:0] OP_SW    = 6'h2B;

   typedef struct packed {
      logic [5:0]  opcode;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
      logic [5:0]  funct;
      logic [31:0] imm;
      logic [31:0] jtarget;
      itype_e      itype;
      logic        illegal;
      logic [31:0] pc;
   } decoded_t;

   function automatic logic op_supported(input logic [5:0] op);
      return op inside {OP_RTYPE, [OP_J:OP_LUI], OP_LB, OP_LH, OP_LW,
                        OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
   endfunction

   function automatic decoded_t decode_instr(input logic [31:0] instr,
                                             input logic [31:0] pc);
      decoded_t    d;
      logic [31:0] pc4;
      d         = '0;
      pc4       = pc + 32'd4;
      d.opcode  = instr[31:26];
      d.pc      = pc;
      d.illegal = !op_supported(instr[31:26]);
      case (instr[31:26])
         OP_RTYPE: begin
            d.itype = IT_R;
            d.rs    = instr[25:21];
            d.rt    = instr[20:16];
            d.rd    = instr[15:11];
            d.shamt = instr[10:6];
            d.funct = instr[5:0];
         end
         OP_J, OP_JAL: begin
            d.itype   = IT_J;
            d.jtarget = {pc4[31:28], instr[25:0], 2'b00};
         end
         default: begin
            // unsupported opcodes also land here and travel on as I-type
            d.itype = IT_I;
            d.rs    = instr[25:21];
            d.rt    = instr[20:16];
            case (instr[31:26])
               OP_ANDI, OP_ORI, OP_XORI: d.imm = {16'h0, instr[15:0]};
               OP_LUI:                   d.imm = {instr[15:0], 16'h0};
               default:                  d.imm = {{16{instr[15]}}, instr[15:0]};
            endcase
         end
      endcase
      return d;
   endfunction

endpackage

// File: rtl/id_decode_pipe_if.sv
// IF-side and consumer-side handshake bundle of the decode stage.
interface id_decode_pipe_if #(
   parameter int CNT_W = 8
);
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_instr;
   logic [31:0]      in_pc;
   logic             out_valid;
   logic             out_ready;
   logic [5:0]       out_opcode;
   logic [4:0]       out_rs;
   logic [4:0]       out_rt;
   logic [4:0]       out_rd;
   logic [4:0]       out_shamt;
   logic [5:0]       out_funct;
   logic [31:0]      out_imm;
   logic [31:0]      out_jtarget;
   logic [1:0]       out_itype;
   logic             out_illegal;
   logic [31:0]      out_pc;
   logic [CNT_W-1:0] dec_count;

   modport master (
      output flush, in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd,
             out_shamt, out_funct, out_imm, out_jtarget, out_itype,
             out_illegal, out_pc, dec_count
   );

   modport slave (
      input  flush, in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd,
             out_shamt, out_funct, out_imm, out_jtarget, out_itype,
             out_illegal, out_pc, dec_count
   );
endinterface

// File: rtl/id_decode_pipe_fifo.sv
// Synchronous FIFO of decoded records; flush empties it in one cycle.
module id_fifo
   import mips_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     i_flush,
   input  logic     i_push,
   input  decoded_t i_data,
   input  logic     i_pop,
   output decoded_t o_data,
   output logic     o_full,
   output logic     o_empty
);
   localparam int unsigned DW = $clog2(DEPTH);
   localparam logic [DW:0] FULL_CNT = (DW+1)'(DEPTH);

   decoded_t      r_mem [DEPTH];
   logic [DW-1:0] r_wptr;
   logic [DW-1:0] r_rptr;
   logic [DW:0]   r_count;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (r_count == FULL_CNT);
   assign o_empty = (r_count == '0);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_data  = r_mem[r_rptr];

   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         // DEPTH is a power of two, so pointers wrap by plain overflow
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push && !rst && !i_flush) r_mem[r_wptr] <= i_data;
   end

endmodule

// File: rtl/id_decode_pipe.sv
// MIPS32 ID stage: decodes each accepted instruction and queues the record
// for register read; empty queue presents an all-zero record.
module id_decode_pipe
   import mips_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = 8
) (
   input logic          clk,
   input logic          rst,
   id_decode_pipe_if.slave bus
);
   logic             w_full;
   logic             w_empty;
   logic             w_accept;
   logic             w_pop;
   decoded_t         w_dec;
   decoded_t         w_head;
   decoded_t         w_out;
   logic [CNT_W-1:0] r_dec_count;

   assign bus.in_ready = !rst && !w_full;
   assign w_accept     = bus.in_valid && bus.in_ready && !bus.flush;
   assign w_pop        = !w_empty && bus.out_ready;
   assign w_dec        = decode_instr(bus.in_instr, bus.in_pc);

   id_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_flush (bus.flush),
      .i_push  (w_accept),
      .i_data  (w_dec),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk) begin
      if (rst || bus.flush) r_dec_count <= '0;
      else if (w_accept)    r_dec_count <= r_dec_count + 1'b1;
   end

   // stale storage must never leak onto the bus when nothing is queued
   assign w_out = w_empty ? '0 : w_head;

   assign bus.out_valid   = !w_empty;
   assign bus.out_opcode  = w_out.opcode;
   assign bus.out_rs      = w_out.rs;
   assign bus.out_rt      = w_out.rt;
   assign bus.out_rd      = w_out.rd;
   assign bus.out_shamt   = w_out.shamt;
   assign bus.out_funct   = w_out.funct;
   assign bus.out_imm     = w_out.imm;
   assign bus.out_jtarget = w_out.jtarget;
   assign bus.out_itype   = w_out.itype;
   assign bus.out_illegal = w_out.illegal;
   assign bus.out_pc      = w_out.pc;
   assign bus.dec_count   = r_dec_count;

endmodule

// File: tb/tb_id_decode_pipe.sv
// Bench for id_decode_pipe: constant decode table, directed queue corners and
// a randomized run against a queue-based reference model.
module tb_id_decode_pipe;
   import mips_pkg::*;

   localparam int DEPTH = 4;
   localparam int CNT_W = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   id_decode_pipe_if #(.CNT_W(CNT_W)) bus ();
   id_decode_pipe #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          checks = 0;
   int          errors = 0;
   decoded_t    mq[$];
   int unsigned mcnt = 0;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [1:0]  itype;
      logic [4:0]  rs, rt, rd;
      logic [5:0]  funct;
      logic [31:0] imm;
      logic [31:0] jt;
      logic        ill;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic is_legal(input int unsigned op);
      return op == 0 || (op >= 2 && op <= 15) || op == 32 || op == 33 || op == 35 ||
             op == 36 || op == 37 || op == 40 || op == 41 || op == 43;
   endfunction

   // Reference decode from the instruction-format rules using plain arithmetic.
   function automatic decoded_t ref_decode(input logic [31:0] instr, input logic [31:0] pc);
      decoded_t    d;
      int unsigned op;
      logic [31:0] imm16;
      d     = '0;
      op    = instr >> 26;
      imm16 = instr & 32'hFFFF;
      d.opcode  = 6'(op);
      d.pc      = pc;
      d.illegal = !is_legal(op);
      if (op == 0) begin
         d.itype = IT_R;
         d.rs    = 5'((instr >> 21) & 31);
         d.rt    = 5'((instr >> 16) & 31);
         d.rd    = 5'((instr >> 11) & 31);
         d.shamt = 5'((instr >> 6) & 31);
         d.funct = 6'(instr & 63);
      end else if (op == 2 || op == 3) begin
         d.itype   = IT_J;
         d.jtarget = ((pc + 32'd4) & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) << 2);
      end else begin
         d.itype = IT_I;
         d.rs    = 5'((instr >> 21) & 31);
         d.rt    = 5'((instr >> 16) & 31);
         if (op >= 12 && op <= 14) d.imm = imm16;
         else if (op == 15)        d.imm = imm16 << 16;
         else if (imm16 >= 32768)  d.imm = imm16 | 32'hFFFF_0000;
         else                      d.imm = imm16;
      end
      return d;
   endfunction

   function automatic decoded_t actual_rec();
      decoded_t d;
      d.opcode  = bus.out_opcode;
      d.rs      = bus.out_rs;
      d.rt      = bus.out_rt;
      d.rd      = bus.out_rd;
      d.shamt   = bus.out_shamt;
      d.funct   = bus.out_funct;
      d.imm     = bus.out_imm;
      d.jtarget = bus.out_jtarget;
      d.itype   = itype_e'(bus.out_itype);
      d.illegal = bus.out_illegal;
      d.pc      = bus.out_pc;
      return d;
   endfunction

   task automatic check_model();
      decoded_t e;
      e = '0;
      if (mq.size() != 0) e = mq[0];
      chk("out_valid", bus.out_valid, mq.size() != 0);
      chk("record", actual_rec(), e);
      chk("dec_count", bus.dec_count, CNT_W'(mcnt));
   endtask

   // One clock: drive at negedge, update model at the edge, check at next negedge.
   task automatic cyc(input logic r, input logic f, input logic v,
                      input logic [31:0] instr, input logic [31:0] pc, input logic ordy);
      logic acc, pop;
      rst = r; bus.flush = f; bus.in_valid = v;
      bus.in_instr = instr; bus.in_pc = pc; bus.out_ready = ordy;
      #1;
      chk("in_ready", bus.in_ready, !r && mq.size() < DEPTH);
      acc = v && !r && !f && mq.size() < DEPTH;
      pop = mq.size() != 0 && ordy;
      @(posedge clk);
      if (r || f) begin
         mq.delete();
         mcnt = 0;
      end else begin
         if (pop) void'(mq.pop_front());
         if (acc) begin
            mq.push_back(ref_decode(instr, pc));
            mcnt++;
         end
      end
      @(negedge clk);
      check_model();
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      logic [5:0]  ops [9];
      ops = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h3F};
      w = $urandom;
      if ($urandom_range(0, 1) == 1) w[31:26] = ops[$urandom_range(0, 8)];
      return w;
   endfunction

   initial begin
      decoded_t held;
      rst = 1'b1; bus.flush = 1'b0; bus.in_valid = 1'b0;
      bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 1'b0;

      tbl[0] = '{32'h012A_4020, 32'h0000_0100, 2'd0, 5'd9, 5'd10, 5'd8, 6'h20, 32'h0, 32'h0, 1'b0};
      tbl[1] = '{32'h2108_FFFF, 32'h0000_0104, 2'd1, 5'd8, 5'd8, 5'd0, 6'h00, 32'hFFFF_FFFF, 32'h0, 1'b0};
      tbl[2] = '{32'h3108_FFFF, 32'h0000_0108, 2'd1, 5'd8, 5'd8, 5'd0, 6'h00, 32'h0000_FFFF, 32'h0, 1'b0};
      tbl[3] = '{32'h3C08_1234, 32'h0000_010C, 2'd1, 5'd0, 5'd8, 5'd0, 6'h00, 32'h1234_0000, 32'h0, 1'b0};
      tbl[4] = '{32'h0C10_0004, 32'h8000_0010, 2'd2, 5'd0, 5'd0, 5'd0, 6'h00, 32'h0, 32'h8040_0010, 1'b0};
      tbl[5] = '{32'hFC21_FFFE, 32'h0000_0114, 2'd1, 5'd1, 5'd1, 5'd0, 6'h00, 32'hFFFF_FFFE, 32'h0, 1'b1};
      tbl[6] = '{32'h2405_0007, 32'h0000_0118, 2'd1, 5'd0, 5'd5, 5'd0, 6'h00, 32'h0000_0007, 32'h0, 1'b0};

      @(negedge clk);
      cyc(1'b1, 1'b0, 1'b1, 32'h1234_5678, 32'h0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      chk("reset out_valid", bus.out_valid, 1'b0);
      chk("reset record", actual_rec(), '0);

      // decode table: push one into an empty queue, check fields, then pop it
      for (int i = 0; i < 7; i++) begin
         cyc(1'b0, 1'b0, 1'b1, tbl[i].instr, tbl[i].pc, 1'b0);
         if (i == 0) chk("first dec_count", bus.dec_count, 1);
         chk("tbl itype", bus.out_itype, tbl[i].itype);
         chk("tbl rs", bus.out_rs, tbl[i].rs);
         chk("tbl rt", bus.out_rt, tbl[i].rt);
         chk("tbl rd", bus.out_rd, tbl[i].rd);
         chk("tbl funct", bus.out_funct, tbl[i].funct);
         chk("tbl imm", bus.out_imm, tbl[i].imm);
         chk("tbl jtarget", bus.out_jtarget, tbl[i].jt);
         chk("tbl illegal", bus.out_illegal, tbl[i].ill);
         chk("tbl opcode", bus.out_opcode, tbl[i].instr[31:26]);
         cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      end

      // back-pressure: fill past DEPTH with head held, then stream through wrap
      cyc(1'b0, 1'b0, 1'b1, rand_instr(), 32'h0000_4000, 1'b0);
      held = actual_rec();
      for (int i = 1; i <= DEPTH; i++) begin
         cyc(1'b0, 1'b0, 1'b1, rand_instr(), 32'h0000_4000 + 32'(4 * i), 1'b0);
         chk("held head", actual_rec(), held);
      end
      chk("full in_ready", bus.in_ready, 1'b0);
      for (int i = 0; i < 3 * DEPTH + 2; i++)
         cyc(1'b0, 1'b0, 1'b1, rand_instr(), 32'h0000_5000 + 32'(4 * i), 1'b1);

      // flush with two queued and a concurrent offer
      cyc(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 32'h012A_4020, 32'h100, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 32'h2108_FFFF, 32'h104, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 32'h3C08_DEAD, 32'h108, 1'b1);
      chk("flush out_valid", bus.out_valid, 1'b0);
      chk("flush dec_count", bus.dec_count, 0);
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      chk("flush dropped", bus.out_valid, 1'b0);

      // reset in the middle of traffic
      cyc(1'b0, 1'b0, 1'b1, rand_instr(), 32'h200, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, rand_instr(), 32'h204, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, rand_instr(), 32'h208, 1'b1);
      chk("midrst record", actual_rec(), '0);
      chk("midrst dec_count", bus.dec_count, 0);
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

      // long stream so dec_count wraps
      for (int i = 0; i < 270; i++)
         cyc(1'b0, 1'b0, 1'b1, rand_instr(), 32'(i * 4), 1'b1);

      // random traffic
      for (int i = 0; i < 400; i++)
         cyc($urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0,
             $urandom_range(0, 3) != 0, rand_instr(), $urandom & 32'hFFFF_FFFC,
             $urandom_range(0, 2) != 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_decode_pipe.md
# id_decode_pipe

Parametrised MIPS32 instruction-decode pipeline stage between IF and the register-read/EX stages. Splits each accepted instruction into its fields and classifies it as R/I/J. Produces a sign- or zero-extended immediate and the absolute jump target, and flags unsupported opcodes. Decoded records are buffered in a DEPTH-entry queue with valid/ready handshakes on both sides, plus a pipeline flush.

## Interface
- DEPTH, 2, decoded-record queue entries; power of two, ≥2
- CNT_W, 8, width of the decoded-instruction counter
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all buffered and incoming instructions this cycle
- in_valid  in  1  IF presents an instruction
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction word
- in_pc  in  32  PC of in_instr
- out_valid  out  1  head record valid
- out_ready  in  1  consumer takes head record
- out_opcode  out  6  instr[31:26]
- out_rs / out_rt / out_rd  out  5 each  register specifiers
- out_shamt  out  5  instr[10:6]
- out_funct  out  6  instr[5:0]
- out_imm  out  32  extended immediate
- out_jtarget  out  32  {pc+4[31:28], instr[25:0], 2'b00}
- out_itype  out  2  0=R, 1=I, 2=J
- out_illegal  out  1  opcode not in supported set
- out_pc  out  32  PC carried with the record
- dec_count  out  CNT_W  instructions accepted since reset or flush, wraps

## Operation
- Accept on in_valid && in_ready && !flush. Decode combinationally, then push the record into the queue.
- R-type (opcode 0x00):
  - rs, rt, rd, shamt and funct are taken from the instruction.
  - imm = 0 and jtarget = 0.
- J-type (0x02 J, 0x03 JAL):
  - jtarget is computed as above.
  - rs, rt, rd, shamt, funct and imm are all 0.
- I-type (all other opcodes):
  - rs, rt and imm16 are taken from the instruction.
  - rd, shamt, funct and jtarget are 0.
  - imm is zero-extended for 0x0C ANDI, 0x0D ORI and 0x0E XORI.
  - imm is {imm16, 16'h0} for 0x0F LUI.
  - imm is sign-extended for every other I-type opcode.
- Supported set: 0x00, 0x02–0x0F, 0x20, 0x21, 0x23, 0x24, 0x25, 0x28, 0x29, 0x2B.
  - Any other opcode sets illegal = 1 and is still decoded as I-type and passed through.
- Pop when out_valid && out_ready.
- Push and pop in the same cycle leave occupancy unchanged.
- in_ready = !rst && (occupancy < DEPTH). There is no pass-through when full, even if out_ready is high.
- Empty queue: out_valid = 0 and every out_* data field is 0.
- dec_count increments by 1 per accept and wraps at 2^CNT_W.

## Timing
- Reset (rst high at an edge), next cycle:
  - occupancy 0, out_valid 0, all data outputs 0, dec_count 0.
  - in_ready is 0 while rst is high and 1 the first cycle after.
- Latency: an instruction accepted at edge N is visible on out_* with out_valid = 1 after edge N.
- Queue order is FIFO, and pointers wrap modulo DEPTH.
- out_* must not change while out_valid && !out_ready.
- flush at edge N:
  - occupancy becomes 0 and out_valid is 0 after N.
  - An input offered in cycle N is dropped: in_ready may be high, but there is no push and no count.
  - dec_count resets to 0.
  - A pop in the same cycle has no extra effect.
- Priority: rst > flush > push/pop.

## Structure
- Package mips_pkg holds:
  - the itype_e enum (R/I/J);
  - opcode localparams (OP_RTYPE, OP_J, OP_JAL, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, …);
  - the decoded_t packed struct (all out_* fields except dec_count);
  - a decode_instr(instr, pc) function returning decoded_t.
- Sub-module id_fifo:
  - generic synchronous FIFO of decoded_t with DEPTH;
  - push/pop/flush ports, full/empty outputs;
  - occupancy counter DEPTH_W+1 bits wide.
- The top level contains only accept logic, the decode function call, dec_count and output zeroing.

## Test plan
- Reset, then push 0x012A4020 (add $t0,$t1,$t2) → next cycle: itype R, rs 9, rt 10, rd 8, funct 0x20, imm 0, dec_count 1.
- Push 0x2108FFFF (addi) → imm 0xFFFFFFFF. Push 0x3108FFFF (andi) → imm 0x0000FFFF. Push 0x3C081234 (lui) → imm 0x12340000.
- Push 0x0C100004 (jal) with pc 0x8000_0010 → jtarget 0x8040_0010, rs/rt/imm 0.
- Hold out_ready low and push DEPTH instructions → in_ready drops, outputs stay stable. Then hold out_ready high with a continuous stream → one record per cycle, FIFO order kept across pointer wrap.
- Queue holding 2 records, flush asserted together with in_valid → out_valid 0 next cycle, dropped input never appears, dec_count 0.
- Push opcode 0x3F → illegal 1, itype I, passed through. Assert rst mid-stream → all outputs 0 next cycle.
